// File: rtl/req_ack_pkg.sv
// Shared definitions for the 4-phase req/ack bundled-data CDC link (tx and rx sides).
package req_ack_pkg;

    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic {
        RX_IDLE,
        RX_ACKD
    } rx_state_e;

endpackage

// File: rtl/cdc_sync_bit.sv
// Multi-flop level synchronizer for a single control bit; STAGES clk edges of latency.
module cdc_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/req_ack_4ph_rx.sv
// Receive side of the 4-phase req/ack CDC link: captures din once per req phase into a small FIFO.
// req->ack = SYNC_STAGES+1 edges, capture->val one edge later; ack withheld while the FIFO is full.
module req_ack_4ph_rx
    import req_ack_pkg::*;
#(
    parameter int DW          = 8,
    parameter int DEPTH       = 2,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic          clk_rx,
    input  logic          rst,
    input  logic          req,
    input  logic [DW-1:0] din,
    output logic          ack,
    output logic          val,
    input  logic          rdy,
    output logic [DW-1:0] dout,
    output logic          full
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic            req_s;
    rx_state_e       state_q, state_d;
    logic            ack_q, ack_d;
    logic            cap_en;
    logic            wr_pend_q;
    logic [DW-1:0]   wr_dat_q;
    logic [DW-1:0]   mem [DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic            val_q, full_q;
    logic            push, pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    cdc_sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk (clk_rx),
        .rst (rst),
        .d   (req),
        .q   (req_s)
    );

    // Capture is gated by the registered full flag only, so a pop on the
    // same edge does not make room for this edge's capture.
    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        cap_en  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (req_s && !full_q) begin
                    cap_en  = 1'b1;
                    ack_d   = 1'b1;
                    state_d = RX_ACKD;
                end
            end
            RX_ACKD: begin
                if (!req_s) begin
                    ack_d   = 1'b0;
                    state_d = RX_IDLE;
                end
            end
            default: begin
                ack_d   = 1'b0;
                state_d = RX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_rx) begin
        if (rst) begin
            state_q   <= RX_IDLE;
            ack_q     <= 1'b0;
            wr_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ack_q     <= ack_d;
            wr_pend_q <= cap_en;
        end
    end

    // din is only looked at on the capture edge, when req_s guarantees it is settled.
    always_ff @(posedge clk_rx) begin
        if (cap_en) begin
            wr_dat_q <= din;
        end
    end

    assign push = wr_pend_q;
    assign pop  = val_q && rdy;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_rx) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            val_q    <= 1'b0;
            full_q   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q <= count_d;
            val_q   <= (count_d != '0);
            full_q  <= (count_d == DEPTH_C);
        end
    end

    always_ff @(posedge clk_rx) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_dat_q;
        end
    end

    assign ack  = ack_q;
    assign val  = val_q;
    assign full = full_q;
    assign dout = mem[rd_ptr_q];

endmodule

// File: tb/tb_req_ack_4ph_rx.sv
// Bench for req_ack_4ph_rx: directed handshake cases, then a randomized 4-phase transmitter
// on an unrelated clock checked against a queue-based scoreboard and an occupancy model.
module tb_req_ack_4ph_rx;

    localparam int DW     = 8;
    localparam int DEPTH  = 2;
    localparam int SYNC   = 2;
    localparam int NW     = 1000;
    localparam int TX_TMO = 3000;
    localparam int RX_TMO = 60000;

    logic          clk_rx, clk_tx, rst, req, ack, val, rdy, full;
    logic [DW-1:0] din, dout;

    int n_chk  = 0;
    int n_fail = 0;
    int tx_half = 50;

    logic          seen;
    int            bad;
    logic [DW-1:0] sb_q[$];
    logic [DW-1:0] w;
    logic          tx_ok, tx_done, tx_fail;
    logic          r0, r1, r2;
    logic          ack_p, ack_pp, val_p, rdy_p;
    logic [DW-1:0] dout_p;
    logic          push_m, pop_m;
    int            occ, rcv, cyc, pct;

    req_ack_4ph_rx #(
        .DW          (DW),
        .DEPTH       (DEPTH),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk_rx (clk_rx),
        .rst    (rst),
        .req    (req),
        .din    (din),
        .ack    (ack),
        .val    (val),
        .rdy    (rdy),
        .dout   (dout),
        .full   (full)
    );

    initial begin
        clk_rx = 1'b0;
        forever #150 clk_rx = ~clk_rx;
    end

    // tx edges sit at odd offsets so they never coincide with rx edges or rx-side drives.
    initial begin
        clk_tx = 1'b0;
        #3;
        forever #(tx_half) clk_tx = ~clk_tx;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_rx);
        #1;
    endtask

    task automatic wait_ack(input logic lvl, input string tag);
        int n = 0;
        while (ack !== lvl && n < 40) begin
            tick();
            n++;
        end
        chk(tag, 32'(ack), 32'(lvl));
    endtask

    task automatic send_dir(input logic [DW-1:0] wd, input string tag);
        din = wd;
        req = 1'b1;
        wait_ack(1'b1, {tag, "_ack_rise"});
        req = 1'b0;
        wait_ack(1'b0, {tag, "_ack_fall"});
    endtask

    task automatic tx_send(input logic [DW-1:0] wd, output logic ok);
        int n = 0;
        @(posedge clk_tx);
        din = wd;
        req = 1'b1;
        while (ack !== 1'b1 && n < TX_TMO) begin
            @(posedge clk_tx);
            n++;
        end
        if (ack !== 1'b1) begin
            ok = 1'b0;
            return;
        end
        req = 1'b0;
        din = 8'($urandom);
        n = 0;
        while (ack !== 1'b0 && n < TX_TMO) begin
            @(posedge clk_tx);
            n++;
        end
        ok = (ack === 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        req = 1'b0;
        din = '0;
        rdy = 1'b0;
        tick();
        tick();
        chk("reset_ack", 32'(ack), 32'(0));
        chk("reset_val", 32'(val), 32'(0));
        chk("reset_full", 32'(full), 32'(0));
        rst = 1'b0;

        // single word: ack on the 3rd edge, val one edge later, ack falls 3 edges after req
        din = 8'hA5;
        req = 1'b1;
        tick();
        tick();
        chk("t1_ack_early", 32'(ack), 32'(0));
        tick();
        chk("t1_ack_rise", 32'(ack), 32'(1));
        chk("t1_val_before", 32'(val), 32'(0));
        tick();
        chk("t1_val", 32'(val), 32'(1));
        chk("t1_dout", 32'(dout), 32'(8'hA5));
        req = 1'b0;
        tick();
        tick();
        chk("t1_ack_hold", 32'(ack), 32'(1));
        tick();
        chk("t1_ack_fall", 32'(ack), 32'(0));
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        chk("t1_drained", 32'(val), 32'(0));

        // backpressure with a full FIFO, then a single pop frees one slot
        send_dir(8'h11, "t2_w11");
        send_dir(8'h22, "t2_w22");
        chk("t2_full", 32'(full), 32'(1));
        chk("t2_head", 32'(dout), 32'(8'h11));
        din = 8'h33;
        req = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            tick();
            if (ack !== 1'b0) seen = 1'b1;
        end
        chk("t2_third_ack_low", 32'(seen), 32'(0));
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        chk("t2_push_deferred", 32'(ack), 32'(0));
        chk("t2_after_pop_dout", 32'(dout), 32'(8'h22));
        chk("t2_after_pop_full", 32'(full), 32'(0));
        tick();
        chk("t2_ack_after_room", 32'(ack), 32'(1));
        req = 1'b0;
        wait_ack(1'b0, "t2_w33_ack_fall");
        chk("t2_drain0_val", 32'(val), 32'(1));
        chk("t2_drain0", 32'(dout), 32'(8'h22));
        rdy = 1'b1;
        tick();
        chk("t2_drain1", 32'(dout), 32'(8'h33));
        tick();
        rdy = 1'b0;
        chk("t2_empty", 32'(val), 32'(0));

        // held req: a single capture no matter how long req stays high
        din = 8'h66;
        req = 1'b1;
        bad = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i >= 3 && ack !== 1'b1) bad++;
        end
        chk("t3_ack_held", 32'(bad), 32'(0));
        chk("t3_val", 32'(val), 32'(1));
        chk("t3_dout", 32'(dout), 32'(8'h66));
        chk("t3_not_full", 32'(full), 32'(0));
        req = 1'b0;
        wait_ack(1'b0, "t3_ack_fall");
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        chk("t3_one_push", 32'(val), 32'(0));

        // pop and write on the same edge at count=1
        send_dir(8'h44, "t4_w44");
        chk("t4_head", 32'(dout), 32'(8'h44));
        din = 8'h55;
        req = 1'b1;
        tick();
        tick();
        tick();
        chk("t4_ack", 32'(ack), 32'(1));
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        chk("t4_val", 32'(val), 32'(1));
        chk("t4_dout", 32'(dout), 32'(8'h55));
        chk("t4_not_full", 32'(full), 32'(0));
        req = 1'b0;
        wait_ack(1'b0, "t4_ack_fall");
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        chk("t4_count_one", 32'(val), 32'(0));

        // reset while acknowledged with req still high: one re-capture
        din = 8'h77;
        req = 1'b1;
        repeat (4) tick();
        chk("t5_pre_ack", 32'(ack), 32'(1));
        chk("t5_pre_val", 32'(val), 32'(1));
        rst = 1'b1;
        tick();
        chk("t5_rst_ack", 32'(ack), 32'(0));
        chk("t5_rst_val", 32'(val), 32'(0));
        rst = 1'b0;
        tick();
        tick();
        chk("t5_resync_ack_low", 32'(ack), 32'(0));
        tick();
        chk("t5_recapture_ack", 32'(ack), 32'(1));
        tick();
        chk("t5_recapture_val", 32'(val), 32'(1));
        chk("t5_recapture_dout", 32'(dout), 32'(8'h77));
        req = 1'b0;
        wait_ack(1'b0, "t5_ack_fall");
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        chk("t5_single_dup", 32'(val), 32'(0));

        // randomized transmitter against scoreboard and occupancy model
        tx_done = 1'b0;
        tx_fail = 1'b0;
        r0 = 1'b0; r1 = 1'b0; r2 = 1'b0;
        ack_p = ack; ack_pp = ack; val_p = val; rdy_p = rdy; dout_p = dout;
        occ = 0; rcv = 0; cyc = 0; pct = 50;
        fork
            begin
                for (int i = 0; i < NW; i++) begin
                    if (i == NW / 2) tx_half = 525;
                    repeat ($urandom_range(0, 3)) @(posedge clk_tx);
                    w = 8'($urandom);
                    sb_q.push_back(w);
                    tx_send(w, tx_ok);
                    if (!tx_ok) begin
                        chk("rnd_tx_handshake", 32'(tx_ok), 32'(1));
                        tx_fail = 1'b1;
                        break;
                    end
                end
                tx_done = 1'b1;
            end
            begin
                while (!(tx_done && (tx_fail || sb_q.size() == 0)) && cyc < RX_TMO) begin
                    @(posedge clk_rx);
                    r2 = r1;
                    r1 = r0;
                    r0 = req;
                    #1;
                    cyc++;
                    pop_m  = val_p && rdy_p;
                    push_m = ack_p && !ack_pp;
                    if (pop_m) begin
                        if (sb_q.size() == 0) begin
                            chk("rnd_unexpected_word", 32'(dout_p), 32'hFFFF_FFFF);
                        end else begin
                            chk("rnd_order", 32'(dout_p), 32'(sb_q.pop_front()));
                            rcv++;
                        end
                    end
                    occ = occ + (push_m ? 1 : 0) - (pop_m ? 1 : 0);
                    chk("rnd_val", 32'(val), 32'(occ != 0));
                    chk("rnd_full", 32'(full), 32'(occ == DEPTH));
                    if (ack === 1'b1 && ack_p === 1'b0) begin
                        chk("rnd_ack_rise_req_s", 32'(r2), 32'(1));
                    end
                    if (cyc % 200 == 0) begin
                        case ((cyc / 200) % 3)
                            0:       pct = 50;
                            1:       pct = 15;
                            default: pct = 90;
                        endcase
                    end
                    ack_pp = ack_p;
                    ack_p  = ack;
                    val_p  = val;
                    dout_p = dout;
                    rdy    = (int'($urandom_range(0, 99)) < pct);
                    rdy_p  = rdy;
                end
            end
        join
        chk("rnd_words_rcv", 32'(rcv), 32'(NW));
        chk("rnd_sb_empty", 32'(sb_q.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
